// File: rtl/uart_tx.sv
// UART transmitter: byte in over valid/ready, serial frame out on tx.
// Start, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic          PAR_EN    = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          baud_tc;
  logic          accept;

  // Ready only from idle, enabled and out of reset.
  always_comb begin
    tx_ready = (state_q == S_IDLE) & en & ~RST;
  end

  assign accept  = tx_valid & tx_ready;
  assign baud_tc = (baud_q == BAUD_LAST);
  assign tx      = tx_q;
  assign busy    = busy_q;

  // Next-state, counter and registered-output logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d = S_START;
          baud_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
          shift_d = tx_data & DATA_MASK;
          par_d   = (^(tx_data & DATA_MASK)) ^ PAR_ODD;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (baud_tc) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == BIT_LAST) begin
            if (PAR_EN) begin
              state_d = S_PAR;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PAR: begin
        if (baud_tc) begin
          state_d = S_STOP;
          baud_d  = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_tc) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; synchronous reset aborts any frame and idles the line.
  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (8N1, 8E2, 8O2) at 10 clocks per bit.
// Monitor decodes frames from tx/busy and checks them against a queue.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] vld = 3'b000;
  logic [2:0] rdy_w, tx_w, busy_w;

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u0 (
    .sys_clk(clk), .RST(RST), .en(en), .tx_data(tx_data), .tx_valid(vld[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(2)) u1 (
    .sys_clk(clk), .RST(RST), .en(en), .tx_data(tx_data), .tx_valid(vld[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

  uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(2)) u2 (
    .sys_clk(clk), .RST(RST), .en(en), .tx_data(tx_data), .tx_valid(vld[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

  int   sel = 0;
  logic mon_en = 1'b0;
  logic tx_m, busy_m, rdy_m;

  assign tx_m   = tx_w[sel];
  assign busy_m = busy_w[sel];
  assign rdy_m  = rdy_w[sel];

  typedef struct {
    logic [15:0] bits;
    int nb;
    int len;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] b, input int nb, input int len, input int gap);
    exp_t e;
    e.bits = b;
    e.nb = nb;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Frame monitor: samples tx mid-bit while busy, compares at busy fall.
  initial begin
    logic        in_frame;
    logic [15:0] cap;
    int          idx, idle_cnt, gap_seen;
    exp_t        e;
    logic [15:0] mask;
    in_frame = 1'b0;
    idle_cnt = 1000;
    cap = '0;
    idx = 0;
    gap_seen = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_frame = 1'b0;
        idle_cnt = 1000;
      end else if (busy_m) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          idx = 0;
          cap = '0;
          gap_seen = idle_cnt;
        end
        if ((idx % 10) == 5 && (idx / 10) < 16) cap[idx/10] = tx_m;
        idx++;
      end else if (in_frame) begin
        in_frame = 1'b0;
        idle_cnt = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'(cap), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          mask = 16'((32'd1 << e.nb) - 1);
          chk("frame_bits", 32'(cap & mask), 32'(e.bits));
          chk("frame_len", 32'(idx), 32'(e.len));
          if (e.gap >= 0) chk("frame_gap", 32'(gap_seen), 32'(e.gap));
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  // Offer a byte on instance k and wait for the accepting edge.
  task automatic send(input int k, input logic [7:0] d, input logic hold);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    tx_data = d;
    vld[k] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (rdy_w[k]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) vld[k] = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy_m) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Reset and startup enable.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx_w[0]), 32'd1);
      chk("rst_busy", 32'(busy_w[0]), 32'd0);
      chk("rst_ready", 32'(rdy_w[0]), 32'd0);
    end
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("noen_tx", 32'(tx_w[0]), 32'd1);
      chk("noen_busy", 32'(busy_w[0]), 32'd0);
      chk("noen_ready", 32'(rdy_w), 32'd0);
    end
    en = 1'b1;
    #1;
    chk("en_ready", 32'(rdy_w), 32'h7);
    mon_en = 1'b1;

    // 8N1 0xA5.
    sel = 0;
    push(16'h034A, 10, 100, -1);
    send(0, 8'hA5, 1'b0);
    wait_idle();

    // Even parity, two stops, then odd parity.
    sel = 1;
    push(16'h0E0E, 12, 120, -1);
    send(1, 8'h07, 1'b0);
    wait_idle();
    sel = 2;
    push(16'h0C0E, 12, 120, -1);
    send(2, 8'h07, 1'b0);
    wait_idle();

    // Back-to-back with valid held; byte offered mid-frame is dropped.
    sel = 0;
    push(16'h02AA, 10, 100, -1);
    push(16'h03FE, 10, 100, 1);
    send(0, 8'h55, 1'b1);
    tx_data = 8'h3C;
    repeat (50) @(negedge clk);
    chk("busy_ready", 32'(rdy_w[0]), 32'd0);
    repeat (40) @(negedge clk);
    tx_data = 8'hFF;
    wait_idle();
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    tx_data = 8'h00;
    wait_idle();

    // Mid-frame reset.
    mon_en = 1'b0;
    send(0, 8'h81, 1'b0);
    repeat (44) @(negedge clk);
    chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
    RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx", 32'(tx_w[0]), 32'd1);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_ready", 32'(rdy_w[0]), 32'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", 32'(rdy_w[0]), 32'd1);
    mon_en = 1'b1;
    push(16'h0302, 10, 100, -1);
    send(0, 8'h81, 1'b0);
    wait_idle();

    // Enable dropped mid-frame.
    push(16'h0386, 10, 100, -1);
    send(0, 8'hC3, 1'b0);
    repeat (29) @(negedge clk);
    en = 1'b0;
    vld[0] = 1'b1;
    wait_idle();
    chk("noen_done_tx", 32'(tx_w[0]), 32'd1);
    chk("noen_done_ready", 32'(rdy_w[0]), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("noen_hold_busy", 32'(busy_w[0]), 32'd0);
      chk("noen_hold_ready", 32'(rdy_w[0]), 32'd0);
    end
    vld[0] = 1'b0;
    en = 1'b1;
    #1;
    chk("reen_ready", 32'(rdy_w[0]), 32'd1);

    repeat (5) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
